// File: rtl/path_tracer.sv
// -----------------------------------------------------------------------------
// path_tracer
//
// Walks the predecessor vector left behind by a shortest-path run, starting at
// a destination node and following prev[] back to the source. The path is
// streamed out one node per beat on a valid/ready interface, destination first
// and source last. Unreachable destinations, out-of-range nodes and (optionally)
// cyclic predecessor chains end the trace with error set alongside done.
//
// Optional feature macro:
//   PATH_TRACER_CYCLE_CHECK_EN - when defined, a trace that has already emitted
//                                MAX_NODES beats is treated as a corrupted
//                                (cyclic) chain and ends with error.
//
// Ports:
//   clock                  rising-edge clock
//   reset                  synchronous, active-high reset
//   start                  begin a trace (sampled only in IDLE)
//   source                 node that terminates the trace
//   destination            first node emitted
//   prev_vector_flattened  entry j at [INDEX_WIDTH*j +: INDEX_WIDTH]
//   node_out               current path node
//   node_valid             node_out is valid
//   node_last              node_out is the source (last beat)
//   node_ready             consumer accepts the beat
//   busy                   trace in progress
//   done                   one-cycle pulse at the end of every trace
//   error                  trace failed; held until the next accepted start
//   path_length            beats accepted in the last trace
// -----------------------------------------------------------------------------

`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif

`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif

module path_tracer #(
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [INDEX_WIDTH-1:0]         source,
  input  logic [INDEX_WIDTH-1:0]         destination,
  input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
  output logic [INDEX_WIDTH-1:0]         node_out,
  output logic                           node_valid,
  output logic                           node_last,
  input  logic                           node_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [INDEX_WIDTH:0]           path_length
);

  // All-ones index marks a node that was never reached.
  localparam logic [INDEX_WIDTH-1:0] UNVISITED   = '1;
  localparam logic [INDEX_WIDTH:0]   MAX_NODES_W = (INDEX_WIDTH+1)'(MAX_NODES);

  typedef enum logic [1:0] {IDLE, LOOKUP, EMIT, FINISH} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] current;
  logic [INDEX_WIDTH-1:0] next_node;
  logic [INDEX_WIDTH-1:0] source_q;
  logic [INDEX_WIDTH:0]   hops;
  logic [INDEX_WIDTH-1:0] prev_entry;
  logic                   out_of_range;
  logic                   hop_limit_hit;

  // hops is cleared on start and bumped on every accepted beat, which is
  // exactly what path_length must report, so one register serves both.
  assign path_length = hops;

  assign out_of_range = ({1'b0, current} >= MAX_NODES_W);

`ifdef PATH_TRACER_CYCLE_CHECK_EN
  assign hop_limit_hit = (hops == MAX_NODES_W);
`else
  assign hop_limit_hit = 1'b0;
`endif

  // Predecessor lookup as an explicit mux so an out-of-range current never
  // produces an out-of-bounds part-select; that case is caught in LOOKUP.
  always_comb begin
    prev_entry = UNVISITED;
    for (int j = 0; j < MAX_NODES; j++) begin
      if ({1'b0, current} == (INDEX_WIDTH+1)'(j)) begin
        prev_entry = prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH];
      end
    end
  end

  // Trace FSM: LOOKUP resolves the next step for current, EMIT presents it
  // and waits for the handshake, FINISH produces the done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      current    <= '0;
      next_node  <= '0;
      source_q   <= '0;
      hops       <= '0;
      node_out   <= '0;
      node_valid <= 1'b0;
      node_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            current  <= destination;
            source_q <= source;
            hops     <= '0;
            error    <= 1'b0;
            busy     <= 1'b1;
            state    <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (hop_limit_hit || out_of_range) begin
            error <= 1'b1;
            state <= FINISH;
          end else if (current == source_q) begin
            // The source's own entry is never consulted.
            node_out   <= current;
            node_valid <= 1'b1;
            node_last  <= 1'b1;
            state      <= EMIT;
          end else if (prev_entry == UNVISITED) begin
            error <= 1'b1;
            state <= FINISH;
          end else begin
            next_node  <= prev_entry;
            node_out   <= current;
            node_valid <= 1'b1;
            node_last  <= 1'b0;
            state      <= EMIT;
          end
        end

        EMIT: begin
          if (node_ready) begin
            node_valid <= 1'b0;
            hops       <= hops + 1'b1;
            if (node_last) begin
              state <= FINISH;
            end else begin
              current <= next_node;
              state   <= LOOKUP;
            end
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_tracer.sv
// -----------------------------------------------------------------------------
// tb_path_tracer
//
// Directed testbench for path_tracer (MAX_NODES=8, INDEX_WIDTH=4). Each trace
// is launched by applyStimulus, which records the beats seen on the output
// stream and the cycle numbers of first valid and done; the expected values
// are written out by hand per test. Cycle numbers count falling edges after
// the cycle in which start was driven.
// -----------------------------------------------------------------------------

module tb_path_tracer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  source;
  logic [3:0]  destination;
  logic [31:0] prev_vec;
  logic [3:0]  node_out;
  logic        node_valid;
  logic        node_last;
  logic        node_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [4:0]  path_length;

  int checks = 0;
  int errors = 0;

  // Results of the most recent applyStimulus call; beats hold {last, node}.
  int beats[$];
  int exp_beats[$];
  int first_valid_cyc;
  int done_cyc;
  int held_count;
  int busy_at1;
  int busy_at_done;
  int done_after;

  path_tracer #(
    .MAX_NODES   (8),
    .INDEX_WIDTH (4)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .source                (source),
    .destination           (destination),
    .prev_vector_flattened (prev_vec),
    .node_out              (node_out),
    .node_valid            (node_valid),
    .node_last             (node_last),
    .node_ready            (node_ready),
    .busy                  (busy),
    .done                  (done),
    .error                 (error),
    .path_length           (path_length)
  );

  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic setPrev(input int j, input logic [3:0] val);
    prev_vec[4*j +: 4] = val;
  endtask

  // Launch one trace and watch the stream for up to budget cycles. The beat
  // with index stall_beat is held off for stall_cycles cycles; during the
  // stall, cycles where the DUT still presents hold_node are counted.
  task automatic applyStimulus(input logic [3:0] src, input logic [3:0] dst,
                               input int stall_beat, input int stall_cycles,
                               input logic [3:0] hold_node, input int budget);
    int stall_left;
    int beat_idx;
    beats.delete();
    first_valid_cyc = -1;
    done_cyc        = -1;
    held_count      = 0;
    busy_at1        = -1;
    busy_at_done    = -1;
    stall_left      = stall_cycles;
    beat_idx        = 0;
    @(negedge clock);
    source      = src;
    destination = dst;
    node_ready  = 1'b1;
    start       = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (cyc == 1) busy_at1 = int'(busy);
      if (done) begin
        done_cyc     = cyc;
        busy_at_done = int'(busy);
        break;
      end
      if (node_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (beat_idx == stall_beat && stall_left > 0) begin
          node_ready = 1'b0;
          stall_left--;
          if (node_out == hold_node) held_count++;
        end else begin
          node_ready = 1'b1;
          beats.push_back({27'd0, node_last, node_out});
          beat_idx++;
        end
      end
    end
    @(negedge clock);
    done_after = int'(done);
    node_ready = 1'b1;
  endtask

  task automatic compareBeats(input string tag);
    checkOutput({tag, "_beat_count"}, beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size(); i++) begin
      checkOutput($sformatf("%s_beat%0d", tag, i),
                  (i < beats.size()) ? beats[i] : -1, exp_beats[i]);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_node_out"},    int'(node_out),    0);
    checkOutput({tag, "_node_valid"},  int'(node_valid),  0);
    checkOutput({tag, "_node_last"},   int'(node_last),   0);
    checkOutput({tag, "_busy"},        int'(busy),        0);
    checkOutput({tag, "_done"},        int'(done),        0);
    checkOutput({tag, "_error"},       int'(error),       0);
    checkOutput({tag, "_path_length"}, int'(path_length), 0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    source      = 4'd0;
    destination = 4'd0;
    node_ready  = 1'b1;
    prev_vec    = '1;
    setPrev(0, 4'd0);
    setPrev(1, 4'd0);
    setPrev(2, 4'd1);
    setPrev(3, 4'd2);

    repeat (3) @(negedge clock);
    checkResetState("reset");
    reset = 1'b0;

    // Basic chain 3 -> 2 -> 1 -> 0 with the consumer always ready.
    applyStimulus(4'd0, 4'd3, -1, 0, 4'd0, 60);
    exp_beats = '{3, 2, 1, 16};
    compareBeats("chain");
    checkOutput("chain_first_valid", first_valid_cyc, 2);
    checkOutput("chain_done_cyc",    done_cyc,        10);
    checkOutput("chain_done_pulse",  done_after,      0);
    checkOutput("chain_busy_at1",    busy_at1,        1);
    checkOutput("chain_busy_done",   busy_at_done,    0);
    checkOutput("chain_path_length", int'(path_length), 4);
    checkOutput("chain_error",       int'(error),     0);

    // Same chain, node 2 held off for three cycles.
    applyStimulus(4'd0, 4'd3, 1, 3, 4'd2, 60);
    exp_beats = '{3, 2, 1, 16};
    compareBeats("stall");
    checkOutput("stall_held",        held_count,      3);
    checkOutput("stall_done_cyc",    done_cyc,        13);
    checkOutput("stall_path_length", int'(path_length), 4);
    checkOutput("stall_error",       int'(error),     0);

    // Source equals destination: a single last beat.
    applyStimulus(4'd5, 4'd5, -1, 0, 4'd0, 60);
    exp_beats = '{21};
    compareBeats("single");
    checkOutput("single_done_cyc",    done_cyc,        4);
    checkOutput("single_path_length", int'(path_length), 1);
    checkOutput("single_error",       int'(error),     0);

    // Unreachable destination (prev[6] is unvisited).
    applyStimulus(4'd0, 4'd6, -1, 0, 4'd0, 60);
    exp_beats = {};
    compareBeats("unreach");
    checkOutput("unreach_done_cyc",    done_cyc,        3);
    checkOutput("unreach_error",       int'(error),     1);
    checkOutput("unreach_path_length", int'(path_length), 0);

    // Destination beyond the node table.
    applyStimulus(4'd0, 4'd9, -1, 0, 4'd0, 60);
    exp_beats = {};
    compareBeats("range");
    checkOutput("range_done_cyc",    done_cyc,        3);
    checkOutput("range_error",       int'(error),     1);
    checkOutput("range_path_length", int'(path_length), 0);

    // Cyclic chain 2 <-> 3.
    setPrev(2, 4'd3);
    setPrev(3, 4'd2);
`ifdef PATH_TRACER_CYCLE_CHECK_EN
    applyStimulus(4'd0, 4'd2, -1, 0, 4'd0, 60);
    exp_beats = '{2, 3, 2, 3, 2, 3, 2, 3};
    compareBeats("cycle");
    checkOutput("cycle_done_cyc",    done_cyc,        19);
    checkOutput("cycle_error",       int'(error),     1);
    checkOutput("cycle_path_length", int'(path_length), 8);
`else
    applyStimulus(4'd0, 4'd2, -1, 0, 4'd0, 30);
    checkOutput("cycle_beat_count", beats.size(), 15);
    checkOutput("cycle_no_done",    done_cyc,     -1);
    checkOutput("cycle_beat0",      (beats.size() > 1) ? beats[0] : -1, 2);
    checkOutput("cycle_beat1",      (beats.size() > 1) ? beats[1] : -1, 3);
    checkOutput("cycle_busy",       int'(busy),   1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkResetState("cycle_reset");
`endif
    setPrev(2, 4'd1);
    setPrev(3, 4'd2);

    // Reset while a beat is stalled in EMIT; a mid-trace start is ignored.
    @(negedge clock);
    source      = 4'd0;
    destination = 4'd3;
    node_ready  = 1'b0;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    checkOutput("emit_valid", int'(node_valid), 1);
    checkOutput("emit_node",  int'(node_out),   3);
    source      = 4'd5;
    destination = 4'd5;
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("ignore_node",  int'(node_out),   3);
    checkOutput("ignore_valid", int'(node_valid), 1);
    checkOutput("ignore_busy",  int'(busy),       1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkResetState("emit_reset");

    // Recovery after reset.
    applyStimulus(4'd5, 4'd5, -1, 0, 4'd0, 60);
    exp_beats = '{21};
    compareBeats("recover");
    checkOutput("recover_path_length", int'(path_length), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/path_tracer.md
# path_tracer

Reads the flattened predecessor vector built by the visited-node store after a shortest-path run and walks it backwards from a destination node to the source. It emits the path one node per beat on a valid/ready stream, destination first and source last. It flags unreachable destinations and corrupted (cyclic) predecessor chains. It sits between the Dijkstra core's result storage and any downstream path consumer.

## Interface
- MAX_NODES, `DEFAULT_MAX_NODES: number of predecessor entries.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH: node index width; `UNVISITED` is the no-predecessor marker.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a trace; sampled only in IDLE.
- source  in  INDEX_WIDTH  node that terminates the trace; sampled on accepted start.
- destination  in  INDEX_WIDTH  first node emitted; sampled on accepted start.
- prev_vector_flattened  in  INDEX_WIDTH*MAX_NODES  entry j = bits [INDEX_WIDTH*j+INDEX_WIDTH-1 : INDEX_WIDTH*j]. Must be stable while busy.
- node_out  out  INDEX_WIDTH  current path node.
- node_valid  out  1  node_out is valid.
- node_last  out  1  qualifies node_valid; node_out is the source.
- node_ready  in  1  consumer accepts beat when node_valid && node_ready.
- busy  out  1  high from the cycle after an accepted start until FINISH completes.
- done  out  1  one-cycle pulse at end of every trace, successful or failed.
- error  out  1  set with done on failure; held until the next accepted start.
- path_length  out  INDEX_WIDTH+1  beats accepted in the last trace; held until the next accepted start.

## Operation
- FSM states are IDLE, LOOKUP, EMIT and FINISH. Registers: current, next_node, hops (INDEX_WIDTH+1 bits).
- **IDLE:** when start is high:
  - load current=destination, hops=0, error=0, path_length=0.
  - go to LOOKUP.
- **LOOKUP:** evaluated in this priority order:
  - If current >= MAX_NODES: error=1, go to FINISH.
  - Else if current == source: node_last=1, go to EMIT. The source's own entry is never read.
  - Else if prev[current] == `UNVISITED`: error=1, go to FINISH.
  - Otherwise: next_node=prev[current], node_last=0, go to EMIT.
- **EMIT:**
  - node_valid=1 and node_out=current.
  - On a handshake: hops and path_length increment.
    - If node_last: go to FINISH.
    - Else: current=next_node, go to LOOKUP.
  - Without a handshake, all outputs hold.
- **FINISH:** done=1 for one cycle, busy=0 next, then go to IDLE.
- start is ignored while busy. A start in the same cycle as FINISH is ignored.
- Reset in any state:
  - next state is IDLE.
  - node_out=0, node_valid=0, node_last=0, busy=0, done=0, error=0, path_length=0, hops=0.

## Timing
- Accepted start at edge N gives LOOKUP at N+1 and node_valid high after edge N+2.
- Each subsequent beat's node_valid rises 2 cycles after the previous handshake, so peak throughput is 1 node per 2 cycles.
- node_valid, node_out and node_last are registered and never change while node_valid && !node_ready.
- done rises exactly one cycle after the last handshake, or one cycle after the LOOKUP that detects an error.
- No combinational path from node_ready to any output.

## Configuration
- PATH_TRACER_CYCLE_CHECK_EN defined:
  - In LOOKUP, hops == MAX_NODES is checked first (before all other conditions).
  - When true, error=1 and the FSM goes to FINISH. A cyclic chain therefore stops after MAX_NODES beats.
- PATH_TRACER_CYCLE_CHECK_EN undefined:
  - No hop-limit check.
  - A cyclic chain emits forever, stopped only by reset.
  - hops wraps modulo 2^(INDEX_WIDTH+1).

## Test plan
- MAX_NODES=8, INDEX_WIDTH=4, prev={0:0,1:0,2:1,3:2}, source=0, destination=3, node_ready=1 -> beats 3,2,1,0; node_last only on 0; first valid 2 cycles after start; done one cycle after beat 0; path_length=4; error=0.
- Same setup, node_ready low for 3 cycles while node 2 is presented -> node_out holds 2 and node_valid stays high; no duplicated or skipped beats; path_length=4.
- source=destination=5 -> single beat 5 with node_last=1; path_length=1; error=0.
- destination=6 with prev[6]=`UNVISITED`, source=0 -> no beats; done=1 and error=1 three cycles after start; path_length=0. Destination 9 (≥ MAX_NODES) -> same response.
- With PATH_TRACER_CYCLE_CHECK_EN: prev[2]=3, prev[3]=2, source=0, destination=2 -> 8 beats alternating 2,3, then done=1, error=1, path_length=8.
- Reset asserted during EMIT -> node_valid=0 after the next edge; all outputs are at reset values. A start pulsed mid-trace is ignored and does not alter node_out.
